// File: rtl/fifosc_pkg.sv
// fifosc_pkg: shared definitions for the fifosc controller and its FIFO.
//   state_e    - controller FSM encoding (INIT, RUN, FLUSH)
//   FIFO_DEPTH - word capacity of the fifosc FIFO
package fifosc_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 8;

endpackage : fifosc_pkg

// File: rtl/fifosc_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered last-grant pointer.
//   clk, rst_n - clock, asynchronous active-low reset
//   req        - request vector, one bit per producer
//   enable     - when low, no grant is issued and the pointer holds
//   grant      - one-hot grant (combinational)
//   grant_idx  - encoded index of the granted requester (valid with |grant)
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int RR_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [RR_W-1:0]    grant_idx
);

  logic [RR_W-1:0] rr_ptr;
  logic            found;
  // One extra bit so rr_ptr + k never overflows before the modulo fold.
  logic [RR_W:0]   cand;

  // Scan from rr_ptr+1 upward with wrap; the first set request wins.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (RR_W+1)'(k);
      if (cand >= (RR_W+1)'(NUM_REQ)) begin
        cand = cand - (RR_W+1)'(NUM_REQ);
      end
      if (enable && !found && req[cand[RR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[RR_W-1:0];
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Reset points at the last requester so requester 0 is first in line.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= RR_W'(NUM_REQ - 1);
    end else if (found) begin
      rr_ptr <= grant_idx;
    end
  end

endmodule : rr_arbiter

// File: rtl/fifosc_ctrl.sv
// fifosc_ctrl: shares one single-clock fifosc FIFO between NUM_REQ producers
// and drains it to a single valid/ready consumer.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req, req_data       - producer requests and their data slices
//   ack                 - one-hot, asserted in the cycle the word is inserted
//   flush_req           - single-cycle request to discard FIFO contents
//   busy                - high while initialising or flushing
//   fifo_insert/remove/flush, fifo_di - FIFO control and write data
//   fifo_full/empty, fifo_do          - FIFO status and registered read data
//   out_valid, out_data, out_ready    - consumer interface
module fifosc_ctrl
  import fifosc_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          flush_req,
  output logic                          busy,
  output logic                          fifo_insert,
  output logic                          fifo_remove,
  output logic                          fifo_flush,
  output logic [DATA_WIDTH-1:0]         fifo_di,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_do,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready
);

  localparam int RR_W = $clog2(NUM_REQ);

  state_e            state, state_next;
  logic              run_ok;
  logic              arb_enable;
  logic [NUM_REQ-1:0] grant;
  logic [RR_W-1:0]   grant_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .RR_W    (RR_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .enable    (arb_enable),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // The FIFO has no reset, so INIT always passes through FLUSH.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_RUN;
      ST_RUN:   if (flush_req) state_next = ST_FLUSH;
      default:  state_next = ST_INIT;
    endcase
  end

  // A flush request in RUN blocks both FIFO ports for that cycle so nothing
  // is accepted or delivered from contents about to be discarded.
  always_comb begin
    busy        = (state != ST_RUN);
    fifo_flush  = (state == ST_FLUSH);
    run_ok      = (state == ST_RUN) && !flush_req;
    arb_enable  = run_ok && !fifo_full;
    ack         = grant;
    fifo_insert = |grant;
    // Remove only from a non-empty FIFO and only when the output register
    // is free or being drained this cycle; this also keeps out_data stable
    // during a consumer stall.
    fifo_remove = run_ok && !fifo_empty && (!out_valid || out_ready);
  end

  always_comb begin
    fifo_di = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        fifo_di = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // fifo_do updates on the remove edge, so out_valid follows it directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (state != ST_RUN || flush_req) begin
      out_valid <= 1'b0;
    end else if (fifo_remove) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data = fifo_do;

endmodule : fifosc_ctrl

// File: tb/tb_fifosc_ctrl.sv
// tb_fifosc_ctrl: directed self-checking bench for fifosc_ctrl, with a small
// behavioural 8-deep fifosc model (no reset, registered dataout) attached.
module tb_fifosc_ctrl;

  localparam int DW = 4;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   ack;
  logic            flush_req;
  logic            busy;
  logic            fifo_insert, fifo_remove, fifo_flush;
  logic [DW-1:0]   fifo_di;
  logic            fifo_full, fifo_empty;
  logic [DW-1:0]   fifo_do = '0;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;

  int checks = 0;
  int errors = 0;
  int flush_cnt = 0;

  always #5 clk = ~clk;

  fifosc_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .flush_req   (flush_req),
    .busy        (busy),
    .fifo_insert (fifo_insert),
    .fifo_remove (fifo_remove),
    .fifo_flush  (fifo_flush),
    .fifo_di     (fifo_di),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_do     (fifo_do),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  // FIFO model: starts with stale contents so only a flush makes it empty.
  logic [DW-1:0] mem [8];
  logic [2:0]    wp = 3'd2;
  logic [2:0]    rp = 3'd6;
  logic [3:0]    cnt = 4'd5;

  assign fifo_full  = (cnt == 4'd8);
  assign fifo_empty = (cnt == 4'd0);

  always @(posedge clk) begin
    if (fifo_flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (fifo_insert && !fifo_full) begin
        mem[wp] <= fifo_di;
        wp      <= wp + 3'd1;
      end
      if (fifo_remove && !fifo_empty) begin
        fifo_do <= mem[rp];
        rp      <= rp + 3'd1;
      end
      cnt <= cnt + 4'((fifo_insert && !fifo_full) ? 1 : 0)
                 - 4'((fifo_remove && !fifo_empty) ? 1 : 0);
    end
  end

  always @(posedge clk) begin
    if (fifo_flush) flush_cnt <= flush_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    flush_req = 1'b0;
    out_ready = 1'b0;

    // ---- reset and init sequence ----
    tick();
    tick();
    #3;
    check("rst_busy", busy, 1);
    check("rst_ack", ack, 0);
    check("rst_strobes", {fifo_insert, fifo_remove, fifo_flush}, 0);
    check("rst_out_valid", out_valid, 0);
    tick();
    rst_n = 1'b1;
    #3;
    check("init_busy", busy, 1);
    check("init_flush", fifo_flush, 0);
    check("init_remove", fifo_remove, 0);
    tick();
    #3;
    check("flush_busy", busy, 1);
    check("flush_pulse", fifo_flush, 1);
    tick();
    #3;
    check("run_busy", busy, 0);
    check("run_flush", fifo_flush, 0);
    check("run_out_valid", out_valid, 0);
    check("run_empty", fifo_empty, 1);
    check("flush_count_1", flush_cnt, 1);
    tick();

    // ---- round-robin fill; first word goes straight to the output register ----
    req       = 3'b111;
    req_data  = {4'd3, 4'd2, 4'd1};
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #3;
      check($sformatf("rr_ack_%0d", i), ack, 32'(1 << (i % 3)));
      check($sformatf("rr_di_%0d", i), fifo_di, 32'(i % 3 + 1));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("full_flag_%0d", i), fifo_full, 1);
      check($sformatf("full_ack_%0d", i), ack, 0);
      check($sformatf("full_insert_%0d", i), fifo_insert, 0);
      check($sformatf("full_remove_%0d", i), fifo_remove, 0);
      check($sformatf("full_out_%0d", i), {out_valid, out_data}, {1'b1, 4'd1});
      tick();
    end

    // ---- drain at full throughput ----
    req       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #3;
      check($sformatf("drain_valid_%0d", i), out_valid, 1);
      check($sformatf("drain_data_%0d", i), out_data, 32'(i % 3 + 1));
      check($sformatf("drain_remove_%0d", i), fifo_remove, 32'(i < 8));
      check($sformatf("drain_empty_%0d", i), fifo_empty, 32'(i == 8));
      tick();
    end
    #3;
    check("drain_valid_drop", out_valid, 0);
    tick();

    // ---- single word into empty FIFO: out_valid two cycles after ack ----
    req          = 3'b010;
    req_data     = '0;
    req_data[7:4] = 4'hA;
    #3;
    check("lat_ack", ack, 3'b010);
    check("lat_di", fifo_di, 4'hA);
    check("lat_valid_t0", out_valid, 0);
    tick();
    req = '0;
    #3;
    check("lat_valid_t1", out_valid, 0);
    check("lat_remove_t1", fifo_remove, 1);
    tick();
    #3;
    check("lat_out_t2", {out_valid, out_data}, {1'b1, 4'hA});
    tick();
    #3;
    check("lat_valid_t3", out_valid, 0);
    tick();

    // ---- consumer stall ----
    out_ready     = 1'b0;
    req           = 3'b001;
    req_data[3:0] = 4'd5;
    #3;
    check("stall_ack0", ack, 3'b001);
    tick();
    req            = 3'b100;
    req_data[11:8] = 4'd6;
    #3;
    check("stall_ack2", ack, 3'b100);
    check("stall_first_remove", fifo_remove, 1);
    tick();
    req = '0;
    for (int i = 0; i < 4; i++) begin
      #3;
      check($sformatf("stall_out_%0d", i), {out_valid, out_data}, {1'b1, 4'd5});
      check($sformatf("stall_remove_%0d", i), fifo_remove, 0);
      tick();
    end
    out_ready = 1'b1;
    #3;
    check("stall_release_remove", fifo_remove, 1);
    check("stall_release_data", out_data, 5);
    tick();
    #3;
    check("stall_next_out", {out_valid, out_data}, {1'b1, 4'd6});
    check("stall_next_remove", fifo_remove, 0);
    tick();
    #3;
    check("stall_valid_drop", out_valid, 0);
    tick();

    // ---- flush with 5 words stored and req[2] pending ----
    out_ready = 1'b0;
    req       = 3'b001;
    for (int i = 0; i < 6; i++) begin
      req_data[3:0] = 4'(i + 1);
      #3;
      check($sformatf("pre_flush_ack_%0d", i), ack, 3'b001);
      tick();
    end
    req            = 3'b100;
    req_data[11:8] = 4'd7;
    out_ready      = 1'b1;
    flush_req      = 1'b1;
    #3;
    check("fr_not_empty", fifo_empty, 0);
    check("fr_ack", ack, 0);
    check("fr_insert", fifo_insert, 0);
    check("fr_remove", fifo_remove, 0);
    check("fr_busy", busy, 0);
    tick();
    // A repeated request while flushing must not extend the flush.
    #3;
    check("fl_flush", fifo_flush, 1);
    check("fl_busy", busy, 1);
    check("fl_ack", ack, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_remove", fifo_remove, 0);
    tick();
    flush_req = 1'b0;
    #3;
    check("post_fl_busy", busy, 0);
    check("post_fl_empty", fifo_empty, 1);
    check("post_fl_ack", ack, 3'b100);
    check("post_fl_di", fifo_di, 7);
    check("post_fl_valid", out_valid, 0);
    check("flush_count_2", flush_cnt, 2);
    tick();
    req = '0;
    tick();
    tick();

    // ---- asynchronous reset mid-operation ----
    out_ready     = 1'b0;
    req           = 3'b001;
    req_data[3:0] = 4'd9;
    #3;
    check("ar_ack", ack, 3'b001);
    tick();
    req = '0;
    tick();
    #3;
    check("ar_valid_before", out_valid, 1);
    tick();
    req = 3'b011;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_after", out_valid, 0);
    check("ar_busy", busy, 1);
    check("ar_ack_blocked", ack, 0);
    tick();
    rst_n = 1'b1;
    #3;
    check("ar_init_flush", fifo_flush, 0);
    tick();
    #3;
    check("ar_flush_pulse", fifo_flush, 1);
    tick();
    // Pointer is back at NUM_REQ-1, so requester 0 wins over requester 1.
    #3;
    check("ar_run_busy", busy, 0);
    check("ar_run_empty", fifo_empty, 1);
    check("ar_ptr_reset", ack, 3'b001);
    check("flush_count_3", flush_cnt, 3);
    tick();
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifosc_ctrl
